sipo_deserializer: RTL and testbench

//   Receive-side partner of the 4-bit parallel-in/serial-out shifter. Collects a

---
 rtl/sipo_deserializer.sv | 110 +++++++++++
 tb/tb_sipo_deserializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a valid/ready word output,
// framing counter and sticky overrun flag.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_in,
    input  logic                       s_valid,
    input  logic                       clr,
    input  logic                       p_ready,
    output logic [WIDTH-1:0]           p_out,
    output logic                       p_valid,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shifted;

    // Register update; reset drops any partial or pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: bit capture, word completion, output handshake, frame restart.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
        overrun_d = overrun_q;

        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], s_in};
        end else begin
            shifted = {s_in, sr_q[WIDTH-1:1]};
        end

        // Consumer takes the held word; a completing word below may refill it.
        if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end

        if (clr) begin
            // Restart framing only; the output holding register is left alone.
            state_d   = IDLE;
            sr_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (s_valid) begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
            unique case (state_q)
                IDLE: begin
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (!p_valid_q || p_ready) begin
                            p_out_d   = shifted;
                            p_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign bit_cnt = cnt_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first
// instance share the same stimulus; expected words are hand-computed.
module tb_sipo_deserializer;

    logic       clk;
    logic       rst_n;
    logic       s_in;
    logic       s_valid;
    logic       clr;
    logic       p_ready;
    logic [3:0] m_out, l_out;
    logic       m_valid, l_valid;
    logic [2:0] m_cnt, l_cnt;
    logic       m_ovr, l_ovr;

    int checks   = 0;
    int failures = 0;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .clr(clr),
        .p_ready(p_ready), .p_out(m_out), .p_valid(m_valid), .bit_cnt(m_cnt),
        .overrun(m_ovr)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .clr(clr),
        .p_ready(p_ready), .p_out(l_out), .p_valid(l_valid), .bit_cnt(l_cnt),
        .overrun(l_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given serial input; samples are taken 1ns after the edge.
    task automatic step(input logic v, input logic b);
        s_valid = v;
        s_in    = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_in    = 1'b0;
    endtask

    // Send a 4-bit word, first bit = w[3].
    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) step(1'b1, w[i]);
    endtask

    initial begin
        logic [3:0] bits;
        rst_n   = 1'b0;
        s_in    = 1'b0;
        s_valid = 1'b0;
        clr     = 1'b0;
        p_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p_out",   32'(m_out),   32'h0);
        check("rst_p_valid", 32'(m_valid), 32'h0);
        check("rst_bit_cnt", 32'(m_cnt),   32'h0);
        check("rst_overrun", 32'(m_ovr),   32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        // Bits 1,0,1,1 back to back with the consumer ready.
        p_ready = 1'b1;
        bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i]);
            check($sformatf("t1_cnt_m%0d", i), 32'(m_cnt), 32'((i + 1) % 4));
            check($sformatf("t1_cnt_l%0d", i), 32'(l_cnt), 32'((i + 1) % 4));
            if (i < 3) check($sformatf("t1_novalid%0d", i), 32'(m_valid), 32'h0);
        end
        check("t1_valid_m", 32'(m_valid), 32'h1);
        check("t1_out_m",   32'(m_out),   32'hB);
        check("t1_valid_l", 32'(l_valid), 32'h1);
        check("t1_out_l",   32'(l_out),   32'hD);
        step(1'b0, 1'b0);
        check("t1_drop_m",  32'(m_valid), 32'h0);
        check("t1_drop_l",  32'(l_valid), 32'h0);

        // Bits 1,1,0,0 with 0..3 idle cycles before each bit.
        bits = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) begin
                step(1'b0, 1'b1);
                check($sformatf("t2_hold%0d_%0d", i, g), 32'(m_cnt), 32'(i));
            end
            step(1'b1, bits[3-i]);
        end
        check("t2_valid_m", 32'(m_valid), 32'h1);
        check("t2_out_m",   32'(m_out),   32'hC);
        check("t2_out_l",   32'(l_out),   32'h3);
        check("t2_cnt",     32'(m_cnt),   32'h0);
        step(1'b0, 1'b0);

        // Consumer stalled: second word overruns and is lost.
        p_ready = 1'b0;
        send_word(4'b0101);
        check("t3_valid1",  32'(m_valid), 32'h1);
        check("t3_out1",    32'(m_out),   32'h5);
        check("t3_novr",    32'(m_ovr),   32'h0);
        send_word(4'b0011);
        check("t3_hold_m",  32'(m_out),   32'h5);
        check("t3_hold_l",  32'(l_out),   32'hA);
        check("t3_ovr_m",   32'(m_ovr),   32'h1);
        check("t3_ovr_l",   32'(l_ovr),   32'h1);
        p_ready = 1'b1;
        step(1'b0, 1'b0);
        check("t3_xfer",    32'(m_valid), 32'h0);
        check("t3_sticky",  32'(m_ovr),   32'h1);
        clr = 1'b1;
        step(1'b0, 1'b0);
        clr = 1'b0;
        check("t3_clr_ovr", 32'(m_ovr),   32'h0);

        // Transfer and completion on the same edge keep p_valid high.
        p_ready = 1'b0;
        send_word(4'b1111);
        check("t4_out1",    32'(m_out),   32'hF);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        p_ready = 1'b1;
        step(1'b1, 1'b1);
        check("t4_valid",   32'(m_valid), 32'h1);
        check("t4_out_m",   32'(m_out),   32'h1);
        check("t4_out_l",   32'(l_out),   32'h8);
        check("t4_ovr",     32'(m_ovr),   32'h0);
        step(1'b0, 1'b0);
        check("t4_drop",    32'(m_valid), 32'h0);

        // clr mid-word discards the partial bits and the bit on that edge.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("t5_cnt2",    32'(m_cnt),   32'h2);
        clr = 1'b1;
        step(1'b1, 1'b1);
        clr = 1'b0;
        check("t5_clr_cnt", 32'(m_cnt),   32'h0);
        check("t5_clr_val", 32'(m_valid), 32'h0);
        send_word(4'b1010);
        check("t5_out_m",   32'(m_out),   32'hA);
        check("t5_out_l",   32'(l_out),   32'h5);
        check("t5_valid",   32'(m_valid), 32'h1);

        // Asynchronous reset mid-word with a word still pending.
        p_ready = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t6_pre_cnt", 32'(m_cnt),   32'h2);
        check("t6_pre_val", 32'(m_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_out", 32'(m_out),   32'h0);
        check("t6_arst_val", 32'(m_valid), 32'h0);
        check("t6_arst_cnt", 32'(m_cnt),   32'h0);
        check("t6_arst_ovr", 32'(m_ovr),   32'h0);
        check("t6_arst_lout", 32'(l_out),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("t6_no_emit", 32'(m_valid), 32'h0);
        check("t6_cnt3",    32'(m_cnt),   32'h3);
        step(1'b1, 1'b0);
        check("t6_emit",    32'(m_valid), 32'h1);
        check("t6_out",     32'(m_out),   32'hE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
